// File: rtl/quad_pkg.sv
// ============================================================================
// Module : quad_pkg
// Brief  : Shared state/phase types and forward-phase lookup for the
//          quadrature step decoder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package quad_pkg;

    typedef enum logic {INIT = 1'b0, TRACK = 1'b1} quad_state_t;

    typedef logic [1:0] quad_phase_t;

    // Gray-code successor of a phase {A,B} in the forward (count-up) direction.
    function automatic quad_phase_t next_fwd(input quad_phase_t p);
        quad_phase_t r;
        case (p)
            2'b00:   r = 2'b01;
            2'b01:   r = 2'b11;
            2'b11:   r = 2'b10;
            default: r = 2'b00;
        endcase
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/quad_sync_filter.sv
// ============================================================================
// Module : quad_sync_filter
// Brief  : One encoder pin: SYNC_STAGES-deep metastability synchroniser,
//          followed by a stability filter when QUAD_FILTER_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module quad_sync_filter #(
    parameter int SYNC_STAGES = 2
`ifdef QUAD_FILTER_EN
    , parameter int FILTER_CYCLES = 4
`endif
) (
    input  logic clk,
    input  logic reset,
    input  logic pin_in,
    output logic pin_out
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], pin_in};
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

`ifdef QUAD_FILTER_EN
    localparam int c_cnt_w = $clog2(FILTER_CYCLES + 1);

    logic [c_cnt_w-1:0] r_cnt;
    logic               r_level;

    // r_cnt tracks how many consecutive samples have disagreed with r_level;
    // any agreeing sample throws the candidate away.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else if (w_sync == r_level) begin
            r_cnt <= '0;
        end else if (r_cnt == c_cnt_w'(FILTER_CYCLES - 1)) begin
            r_level <= w_sync;
            r_cnt   <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign pin_out = r_level;
`else
    assign pin_out = w_sync;
`endif

endmodule

`default_nettype wire

// File: rtl/quad_step_decoder.sv
// ============================================================================
// Module : quad_step_decoder
// Brief  : Quadrature A/B decoder producing a step strobe, direction level,
//          illegal-jump pulse and saturating error count. Optional pin
//          glitch filter enabled by defining QUAD_FILTER_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module quad_step_decoder
    import quad_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4,
    parameter int ERR_W         = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             a_in,
    input  logic             b_in,
    output logic             step,
    output logic             dir,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt
);

`ifdef QUAD_FILTER_EN
    localparam bit c_filt_en = 1'b1;
`else
    localparam bit c_filt_en = 1'b0;
`endif
    localparam int c_init_len = SYNC_STAGES + (c_filt_en ? FILTER_CYCLES : 0);
    localparam int c_init_w   = $clog2(c_init_len + 1);

    logic        w_a;
    logic        w_b;
    quad_phase_t w_phase;

    quad_sync_filter #(
        .SYNC_STAGES   (SYNC_STAGES)
`ifdef QUAD_FILTER_EN
        , .FILTER_CYCLES (FILTER_CYCLES)
`endif
    ) u_sync_a (
        .clk     (clk),
        .reset   (reset),
        .pin_in  (a_in),
        .pin_out (w_a)
    );

    quad_sync_filter #(
        .SYNC_STAGES   (SYNC_STAGES)
`ifdef QUAD_FILTER_EN
        , .FILTER_CYCLES (FILTER_CYCLES)
`endif
    ) u_sync_b (
        .clk     (clk),
        .reset   (reset),
        .pin_in  (b_in),
        .pin_out (w_b)
    );

    assign w_phase = {w_a, w_b};

    quad_state_t         r_state;
    quad_state_t         w_state_nxt;
    logic [c_init_w-1:0] r_init_cnt;
    logic [c_init_w-1:0] w_init_cnt_nxt;
    quad_phase_t         r_prev;
    quad_phase_t         w_prev_nxt;
    logic                r_step;
    logic                w_step_nxt;
    logic                r_dir;
    logic                w_dir_nxt;
    logic                r_err;
    logic                w_err_nxt;
    logic [ERR_W-1:0]    r_err_cnt;
    logic [ERR_W-1:0]    w_err_cnt_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= INIT;
            r_init_cnt <= '0;
            r_prev     <= 2'b00;
            r_step     <= 1'b0;
            r_dir      <= 1'b1;
            r_err      <= 1'b0;
            r_err_cnt  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_init_cnt <= w_init_cnt_nxt;
            r_prev     <= w_prev_nxt;
            r_step     <= w_step_nxt;
            r_dir      <= w_dir_nxt;
            r_err      <= w_err_nxt;
            r_err_cnt  <= w_err_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_init_cnt_nxt = r_init_cnt;
        w_prev_nxt     = r_prev;
        w_step_nxt     = 1'b0;
        w_dir_nxt      = r_dir;
        w_err_nxt      = 1'b0;
        w_err_cnt_nxt  = r_err_cnt;

        case (r_state)
            INIT: begin
                // Wait one cycle past the pipeline depth so the captured
                // phase reflects the real pins, not the flops' reset value.
                if (r_init_cnt == c_init_w'(c_init_len)) begin
                    w_prev_nxt  = w_phase;
                    w_state_nxt = TRACK;
                end else begin
                    w_init_cnt_nxt = r_init_cnt + 1'b1;
                end
            end
            TRACK: begin
                w_prev_nxt = w_phase;
                if (en) begin
                    if (w_phase == next_fwd(r_prev)) begin
                        w_step_nxt = 1'b1;
                        w_dir_nxt  = 1'b1;
                    end else if (r_prev == next_fwd(w_phase)) begin
                        w_step_nxt = 1'b1;
                        w_dir_nxt  = 1'b0;
                    end else if (w_phase == ~r_prev) begin
                        w_err_nxt = 1'b1;
                        if (r_err_cnt != '1) begin
                            w_err_cnt_nxt = r_err_cnt + 1'b1;
                        end
                    end
                end
            end
        endcase
    end

    assign step    = r_step;
    assign dir     = r_dir;
    assign err     = r_err;
    assign err_cnt = r_err_cnt;

endmodule

`default_nettype wire

// File: tb/tb_quad_step_decoder.sv
// ============================================================================
// Module : tb_quad_step_decoder
// Brief  : Directed self-checking bench for quad_step_decoder; also covers
//          the glitch filter when built with QUAD_FILTER_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_quad_step_decoder;

    localparam int SYNC_STAGES   = 2;
    localparam int FILTER_CYCLES = 4;
    localparam int ERR_W         = 8;
`ifdef QUAD_FILTER_EN
    localparam int c_lat = SYNC_STAGES + FILTER_CYCLES + 1;
`else
    localparam int c_lat = SYNC_STAGES + 1;
`endif

    logic             clk   = 1'b0;
    logic             reset = 1'b1;
    logic             en    = 1'b1;
    logic             a_in  = 1'b1;
    logic             b_in  = 1'b1;
    logic             step;
    logic             dir;
    logic             err;
    logic [ERR_W-1:0] err_cnt;

    int         n_checks = 0;
    int         n_errors = 0;
    int         n_steps  = 0;
    int         n_errs   = 0;
    logic [1:0] ph       = 2'b11;

    always #5 clk = ~clk;

    quad_step_decoder #(
        .SYNC_STAGES   (SYNC_STAGES),
        .FILTER_CYCLES (FILTER_CYCLES),
        .ERR_W         (ERR_W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .a_in    (a_in),
        .b_in    (b_in),
        .step    (step),
        .dir     (dir),
        .err     (err),
        .err_cnt (err_cnt)
    );

    // Pulse tally, sampled shortly after each rising edge.
    always @(posedge clk) begin
        #2;
        n_steps += int'(step);
        n_errs  += int'(err);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [1:0] fwd_of(input logic [1:0] p);
        case (p)
            2'b00:   return 2'b01;
            2'b01:   return 2'b11;
            2'b11:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] rev_of(input logic [1:0] p);
        case (p)
            2'b00:   return 2'b10;
            2'b10:   return 2'b11;
            2'b11:   return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    // Drive a new phase at a negedge, check exact latency and one-cycle width.
    task automatic edge_chk(input string tag, input logic [1:0] p,
                            input logic exp_step, input logic exp_err, input logic exp_dir);
        ph   = p;
        a_in = p[1];
        b_in = p[0];
        tick(c_lat - 1);
        check({tag, "_early"}, {step, err}, 2'b00);
        tick(1);
        check({tag, "_step"}, step, exp_step);
        check({tag, "_err"}, err, exp_err);
        check({tag, "_dir"}, dir, exp_dir);
        tick(1);
        check({tag, "_width"}, {step, err}, 2'b00);
        tick(10 - c_lat - 1);
    endtask

    int s0;
    int e0;

    initial begin
        // 1: reset with pins at 11, then INIT must stay silent
        tick(3);
        check("rst_step", step, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_dir", dir, 1'b1);
        check("rst_cnt", err_cnt, 0);
        reset = 1'b0;
        tick(12);
        check("init_steps", n_steps, 0);
        check("init_errs", n_errs, 0);
        check("init_dir", dir, 1'b1);
        check("init_cnt", err_cnt, 0);

        // 2: eight forward edges
        s0 = n_steps;
        for (int i = 0; i < 8; i++) edge_chk("fwd", fwd_of(ph), 1'b1, 1'b0, 1'b1);
        check("fwd_count", n_steps - s0, 8);

        // 3: four forward then four reverse
        s0 = n_steps;
        for (int i = 0; i < 4; i++) edge_chk("mix_f", fwd_of(ph), 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) edge_chk("mix_r", rev_of(ph), 1'b1, 1'b0, 1'b0);
        check("mix_count", n_steps - s0, 8);
        check("mix_dir", dir, 1'b0);

        // 4: illegal 00->11 jump, then saturation
        edge_chk("to01", rev_of(ph), 1'b1, 1'b0, 1'b0);
        edge_chk("to00", rev_of(ph), 1'b1, 1'b0, 1'b0);
        check("pre_jump_ph", ph, 2'b00);
        edge_chk("jump", 2'b11, 1'b0, 1'b1, 1'b0);
        check("jump_cnt", err_cnt, 1);
        s0 = n_steps;
        e0 = n_errs;
        for (int i = 0; i < 256; i++) begin
            ph   = ~ph;
            a_in = ph[1];
            b_in = ph[0];
            tick(c_lat);
        end
        tick(c_lat + 2);
        check("sat_cnt", err_cnt, 255);
        check("sat_errs", n_errs - e0, 256);
        check("sat_steps", n_steps - s0, 0);
        check("sat_dir", dir, 1'b0);

        // 5: edges while disabled are absorbed silently
        s0 = n_steps;
        e0 = n_errs;
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ph   = fwd_of(ph);
            a_in = ph[1];
            b_in = ph[0];
            tick(6);
        end
        en = 1'b1;
        tick(12);
        check("dis_steps", n_steps - s0, 0);
        check("dis_errs", n_errs - e0, 0);
        edge_chk("reen", fwd_of(ph), 1'b1, 1'b0, 1'b1);
        check("reen_count", n_steps - s0, 1);

`ifdef QUAD_FILTER_EN
        // 6: short glitch on A is swallowed, held level passes
        s0 = n_steps;
        e0 = n_errs;
        a_in = ~ph[1];
        tick(2);
        a_in = ph[1];
        tick(15);
        check("glitch_steps", n_steps - s0, 0);
        check("glitch_errs", n_errs - e0, 0);
        edge_chk("held", rev_of(ph), 1'b1, 1'b0, 1'b0);
`endif

        // 7: reset mid-operation, pins jump during reset
        edge_chk("pre_rst", rev_of(ph), 1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        ph    = ~ph;
        a_in  = ph[1];
        b_in  = ph[0];
        tick(1);
        check("mid_rst_dir", dir, 1'b1);
        check("mid_rst_cnt", err_cnt, 0);
        check("mid_rst_pulses", {step, err}, 2'b00);
        tick(2);
        s0 = n_steps;
        e0 = n_errs;
        reset = 1'b0;
        tick(15);
        check("rerun_steps", n_steps - s0, 0);
        check("rerun_errs", n_errs - e0, 0);
        edge_chk("post_rst", fwd_of(ph), 1'b1, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
